// File: rtl/rll_key_loader.sv
`default_nettype none
// ============================================================================
//  Module   : rll_key_loader
//  Brief    : Serial key-provisioning front end for RLL16 locked cores.
//             Shifts in a key LSB first with an even-parity bit. Only a key
//             whose parity checks is driven onto key_out. Consecutive failed
//             loads are counted, and too many of them latch a permanent
//             lockout.
//  Revision : 1.0 - initial release
// ============================================================================
module rll_key_loader #(
  parameter int KEY_WIDTH = 16,
  parameter int MAX_FAILS = 3,
  parameter int TIMEOUT   = 255,
  parameter int FAIL_W    = $clog2(MAX_FAILS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 key_valid,
  input  logic                 key_bit,
  output logic                 key_ready,
  input  logic                 key_clear,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_armed,
  output logic                 load_err,
  output logic [FAIL_W-1:0]    fail_cnt,
  output logic                 lockout
);

  localparam int BC_W = $clog2(KEY_WIDTH + 1);
  localparam int IC_W = $clog2(TIMEOUT + 1);
  localparam int SI_W = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;

  localparam logic [BC_W-1:0]   C_KEY_BITS = BC_W'(KEY_WIDTH);
  localparam logic [IC_W-1:0]   C_TIMEOUT  = IC_W'(TIMEOUT);
  localparam logic [FAIL_W-1:0] C_MAX_FAIL = FAIL_W'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CHECK   = 3'd2,
    S_ARMED   = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [IC_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic [KEY_WIDTH-1:0]  shadow_q, shadow_d;
  logic                  parity_q, parity_d;
  logic [KEY_WIDTH-1:0]  key_out_q, key_out_d;
  logic                  key_armed_q, key_armed_d;
  logic                  key_ready_q, key_ready_d;
  logic                  load_err_q, load_err_d;
  logic [FAIL_W-1:0]     fail_cnt_q, fail_cnt_d;
  logic                  lockout_q, lockout_d;

  logic                  w_hs;
  logic                  w_fail;
  logic [FAIL_W-1:0]     w_fail_inc;

  assign w_hs       = key_valid & key_ready_q;
  assign w_fail_inc = (fail_cnt_q == C_MAX_FAIL) ? fail_cnt_q
                                                 : fail_cnt_q + FAIL_W'(1);

  // Next-state and registered-output logic for the load/check/arm sequence.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    shadow_d    = shadow_q;
    parity_d    = parity_q;
    key_out_d   = key_out_q;
    key_armed_d = key_armed_q;
    load_err_d  = 1'b0;
    fail_cnt_d  = fail_cnt_q;
    lockout_d   = lockout_q;
    w_fail      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d    = S_LOAD;
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
          shadow_d   = '0;
        end
      end

      S_LOAD: begin
        // A restart wins over a timeout and over a same-cycle bit.
        if (load_start) begin
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
          shadow_d   = '0;
        end else if (idle_cnt_q == C_TIMEOUT) begin
          w_fail = 1'b1;
        end else if (w_hs) begin
          idle_cnt_d = '0;
          if (bit_cnt_q == C_KEY_BITS) begin
            parity_d = key_bit;
            state_d  = S_CHECK;
          end else begin
            shadow_d[bit_cnt_q[SI_W-1:0]] = key_bit;
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end else if (idle_cnt_q != C_TIMEOUT) begin
          idle_cnt_d = idle_cnt_q + IC_W'(1);
        end
      end

      S_CHECK: begin
        if ((^shadow_q ^ parity_q) == 1'b0) begin
          key_out_d   = shadow_q;
          key_armed_d = 1'b1;
          fail_cnt_d  = '0;
          state_d     = S_ARMED;
        end else begin
          w_fail = 1'b1;
        end
        shadow_d = '0;
      end

      S_ARMED: begin
        // The old key is withdrawn on the same edge that leaves ARMED.
        if (key_clear) begin
          key_out_d   = '0;
          key_armed_d = 1'b0;
          state_d     = S_IDLE;
        end else if (load_start) begin
          key_out_d   = '0;
          key_armed_d = 1'b0;
          bit_cnt_d   = '0;
          idle_cnt_d  = '0;
          shadow_d    = '0;
          state_d     = S_LOAD;
        end
      end

      S_LOCKOUT: begin
        lockout_d   = 1'b1;
        key_out_d   = '0;
        key_armed_d = 1'b0;
      end

      default: begin
        state_d     = S_IDLE;
        key_out_d   = '0;
        key_armed_d = 1'b0;
      end
    endcase

    // Shared failure path for parity errors and load timeouts.
    if (w_fail) begin
      load_err_d  = 1'b1;
      fail_cnt_d  = w_fail_inc;
      key_out_d   = '0;
      key_armed_d = 1'b0;
      shadow_d    = '0;
      if (w_fail_inc == C_MAX_FAIL) begin
        state_d   = S_LOCKOUT;
        lockout_d = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end

    key_ready_d = (state_d == S_LOAD);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      shadow_q    <= '0;
      parity_q    <= 1'b0;
      key_out_q   <= '0;
      key_armed_q <= 1'b0;
      key_ready_q <= 1'b0;
      load_err_q  <= 1'b0;
      fail_cnt_q  <= '0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      shadow_q    <= shadow_d;
      parity_q    <= parity_d;
      key_out_q   <= key_out_d;
      key_armed_q <= key_armed_d;
      key_ready_q <= key_ready_d;
      load_err_q  <= load_err_d;
      fail_cnt_q  <= fail_cnt_d;
      lockout_q   <= lockout_d;
    end
  end

  assign key_out   = key_out_q;
  assign key_armed = key_armed_q;
  assign key_ready = key_ready_q;
  assign load_err  = load_err_q;
  assign fail_cnt  = fail_cnt_q;
  assign lockout   = lockout_q;

endmodule
`default_nettype wire

// File: tb/tb_rll_key_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rll_key_loader
//  Brief    : Scoreboard bench for rll_key_loader. Stimulus pushes each
//             expected arm/error/lockout event. A negedge monitor pops and
//             compares those events as the DUT raises them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rll_key_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_bit = 1'b0;
  logic        key_clear = 1'b0;
  logic        key_ready;
  logic [15:0] key_out;
  logic        key_armed;
  logic        load_err;
  logic [1:0]  fail_cnt;
  logic        lockout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] key;
    logic [1:0]  fc;
  } resp_t;

  localparam logic [1:0] EV_ARM  = 2'd1;
  localparam logic [1:0] EV_ERR  = 2'd2;
  localparam logic [1:0] EV_LOCK = 2'd3;

  resp_t exp_q[$];
  logic  p_armed = 1'b0;
  logic  p_lock  = 1'b0;

  rll_key_loader #(.KEY_WIDTH(16), .MAX_FAILS(3), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .key_valid(key_valid),
    .key_bit(key_bit), .key_ready(key_ready), .key_clear(key_clear),
    .key_out(key_out), .key_armed(key_armed), .load_err(load_err),
    .fail_cnt(fail_cnt), .lockout(lockout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic resp_t mk(input logic [1:0] k, input logic [15:0] v, input logic [1:0] f);
    resp_t r;
    r.kind = k; r.key = v; r.fc = f;
    return r;
  endfunction

  task automatic handle(input logic [1:0] kind);
    resp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_key_out", key_out, (e.kind == EV_ARM) ? e.key : 16'h0);
      chk("event_fail_cnt", fail_cnt, e.fc);
    end
  endtask

  // Monitor: turn DUT output edges into events and score them.
  always @(negedge clk) begin
    if (!rst_n) begin
      p_armed = 1'b0;
      p_lock  = 1'b0;
    end else begin
      if (load_err) handle(EV_ERR);
      if (key_armed && !p_armed) handle(EV_ARM);
      if (lockout && !p_lock) handle(EV_LOCK);
      if (key_out != 16'h0) chk("key_out_only_when_armed", key_armed, 1);
      p_armed = key_armed;
      p_lock  = lockout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic clear_key();
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int n = 0;
    key_valid = 1'b1;
    key_bit   = b;
    while (!key_ready && n < 20) begin
      tick();
      n++;
    end
    if (!key_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: got key_ready 0 expected 1 within 20 cycles");
    end
    tick();
    key_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] k, input logic p, input logic pass);
    for (int i = 0; i < 16; i++) send_bit(k[i]);
    send_bit(p);
    chk("check_cycle_armed", key_armed, 0);
    chk("check_cycle_ready", key_ready, 0);
    tick();
    chk("armed_after_check", key_armed, pass);
    chk("err_after_check", load_err, !pass);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_key_out", key_out, 0);
    chk("rst_key_armed", key_armed, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_key_ready", key_ready, 0);
    rst_n = 1'b1;
    tick();

    // Good load of A5C3 (8 ones, parity 0)
    exp_q.push_back(mk(EV_ARM, 16'hA5C3, 2'd0));
    start_load();
    chk("ready_in_load", key_ready, 1);
    send_frame(16'hA5C3, 1'b0, 1'b1);
    chk("good_key_out", key_out, 16'hA5C3);
    chk("good_fail_cnt", fail_cnt, 0);
    clear_key();
    chk("clear_key_out", key_out, 0);
    chk("clear_armed", key_armed, 0);
    drain(5);

    // Bad parity, then a good load clears fail_cnt
    exp_q.push_back(mk(EV_ERR, 16'h0, 2'd1));
    start_load();
    send_frame(16'hA5C3, 1'b1, 1'b0);
    chk("bad_fail_cnt", fail_cnt, 1);
    chk("bad_key_out", key_out, 0);
    chk("bad_ready_idle", key_ready, 0);
    tick();
    chk("err_one_cycle", load_err, 0);
    exp_q.push_back(mk(EV_ARM, 16'hA5C3, 2'd0));
    start_load();
    send_frame(16'hA5C3, 1'b0, 1'b1);
    chk("recover_fail_cnt", fail_cnt, 0);
    clear_key();
    drain(5);

    // Three bad loads -> lockout
    for (int n = 1; n <= 3; n++) begin
      exp_q.push_back(mk(EV_ERR, 16'h0, 2'(n)));
      if (n == 3) exp_q.push_back(mk(EV_LOCK, 16'h0, 2'd3));
      start_load();
      send_frame(16'hA5C3, 1'b1, 1'b0);
    end
    chk("lockout_set", lockout, 1);
    chk("lockout_fail_cnt", fail_cnt, 3);
    start_load();
    key_valid = 1'b1;
    key_bit   = 1'b1;
    repeat (17) tick();
    key_valid = 1'b0;
    clear_key();
    tick();
    chk("lock_hold", lockout, 1);
    chk("lock_key_out", key_out, 0);
    chk("lock_ready", key_ready, 0);
    chk("lock_armed", key_armed, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("unlock_lockout", lockout, 0);
    chk("unlock_fail_cnt", fail_cnt, 0);
    tick();
    drain(5);

    // Timeout after 8 bits
    exp_q.push_back(mk(EV_ERR, 16'h0, 2'd1));
    start_load();
    for (int i = 0; i < 8; i++) send_bit(1'(i));
    drain(300);
    chk("timeout_ready", key_ready, 0);
    chk("timeout_fail_cnt", fail_cnt, 1);

    // Restart after 8 bits, then a full good frame
    start_load();
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    start_load();
    exp_q.push_back(mk(EV_ARM, 16'hA5C3, 2'd0));
    send_frame(16'hA5C3, 1'b0, 1'b1);
    chk("restart_key_out", key_out, 16'hA5C3);
    chk("restart_fail_cnt", fail_cnt, 0);
    drain(5);

    // Reload from ARMED hides the old key immediately
    start_load();
    chk("reload_key_out", key_out, 0);
    chk("reload_armed", key_armed, 0);
    chk("reload_ready", key_ready, 1);
    exp_q.push_back(mk(EV_ARM, 16'h0001, 2'd0));
    send_frame(16'h0001, 1'b1, 1'b1);
    chk("reload_new_key", key_out, 16'h0001);
    drain(5);

    // key_clear beats load_start
    key_clear  = 1'b1;
    load_start = 1'b1;
    tick();
    key_clear  = 1'b0;
    load_start = 1'b0;
    chk("clr_pri_key_out", key_out, 0);
    chk("clr_pri_armed", key_armed, 0);
    chk("clr_pri_ready", key_ready, 0);
    tick();
    chk("clr_pri_ready_hold", key_ready, 0);

    // Restart coinciding with the parity handshake: no CHECK
    start_load();
    for (int i = 0; i < 16; i++) send_bit(i[0]);
    key_valid  = 1'b1;
    key_bit    = 1'b0;
    load_start = 1'b1;
    tick();
    key_valid  = 1'b0;
    load_start = 1'b0;
    chk("par_restart_ready", key_ready, 1);
    tick();
    chk("par_restart_armed", key_armed, 0);
    chk("par_restart_err", load_err, 0);
    exp_q.push_back(mk(EV_ARM, 16'hA5C3, 2'd0));
    send_frame(16'hA5C3, 1'b0, 1'b1);
    chk("par_restart_key", key_out, 16'hA5C3);

    drain(10);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
